// File: rtl/max_pooling_if.sv
// Window-sample / result bundle between the activation stage and the max-pooling block.
//   ifm_input  : POOL_SIZE signed samples of one pooling window (driven by master)
//   ifm_output : signed window maximum (driven by slave)
// master = upstream producer / consumer side, slave = max_pooling.
interface max_pooling_if #(
  parameter int unsigned INPUT_WIDTH  = 20,
  parameter int unsigned OUTPUT_WIDTH = 20,
  parameter int unsigned POOL_SIZE    = 4
) ();

  logic signed [INPUT_WIDTH-1:0]  ifm_input [POOL_SIZE];
  logic signed [OUTPUT_WIDTH-1:0] ifm_output;

  modport master (
    output ifm_input,
    input  ifm_output
  );

  modport slave (
    input  ifm_input,
    output ifm_output
  );

endinterface

// File: rtl/max_pooling.sv
// Signed max-pooling reduction over one window of POOL_SIZE samples.
// Fully pipelined binary comparator tree, one window accepted every cycle.
//   clk   : clock, all state updates on the rising edge
//   rst_n : synchronous reset, active HIGH (1 = reset), clears every pipeline register
//   pool  : max_pooling_if slave (ifm_input window in, registered ifm_output maximum out)
// Latency is ceil(log2(POOL_SIZE)) cycles (1 cycle when POOL_SIZE is 1).
module max_pooling #(
  parameter int unsigned INPUT_WIDTH  = 20,
  parameter int unsigned OUTPUT_WIDTH = 20,
  parameter int unsigned POOL_SIZE    = 4
) (
  input logic          clk,
  input logic          rst_n,
  max_pooling_if.slave pool
);

  localparam int unsigned IW = INPUT_WIDTH;
  localparam int unsigned OW = OUTPUT_WIDTH;

  // Element count of tree level k (level 0 is the raw window).
  function automatic int unsigned level_cnt(input int unsigned k);
    return (POOL_SIZE + (32'd1 << k) - 32'd1) >> k;
  endfunction

  // Offset of tree level k (k >= 1) inside the flattened node register array.
  function automatic int unsigned level_off(input int unsigned k);
    int unsigned s;
    s = 0;
    for (int unsigned j = 1; j < k; j++) s += level_cnt(j);
    return s;
  endfunction

  // The final register is the output register, so only levels 1..Levels-1 live in node_q.
  localparam int unsigned Levels    = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
  localparam int unsigned NodeTotal = level_off(Levels);
  localparam int unsigned NodeAlloc = (NodeTotal > 0) ? NodeTotal : 1;
  localparam int unsigned NLast     = level_cnt(Levels - 1);
  localparam int unsigned OffLast   = level_off(Levels - 1);

  logic signed [IW-1:0] node_q [NodeAlloc];

  // Intermediate tree levels.
  for (genvar k = 1; k < Levels; k++) begin : g_level
    localparam int unsigned NIn    = level_cnt(k - 1);
    localparam int unsigned NOut   = level_cnt(k);
    localparam int unsigned OffIn  = level_off(k - 1);
    localparam int unsigned OffOut = level_off(k);

    for (genvar i = 0; i < NOut; i++) begin : g_node
      logic signed [IW-1:0] lhs;
      logic signed [IW-1:0] win;

      if (k == 1) begin : g_lhs_in
        assign lhs = pool.ifm_input[2*i];
      end else begin : g_lhs_q
        assign lhs = node_q[OffIn + 2*i];
      end

      if (2*i + 1 < NIn) begin : g_pair
        logic signed [IW-1:0] rhs;
        if (k == 1) begin : g_rhs_in
          assign rhs = pool.ifm_input[2*i + 1];
        end else begin : g_rhs_q
          assign rhs = node_q[OffIn + 2*i + 1];
        end
        assign win = (rhs > lhs) ? rhs : lhs;
      end else begin : g_pass
        // Odd element count: the last element rides through unchanged.
        assign win = lhs;
      end

      always_ff @(posedge clk) begin
        if (rst_n) begin
          node_q[OffOut + i] <= '0;
        end else begin
          node_q[OffOut + i] <= win;
        end
      end
    end
  end

  // Final comparison feeding the output register.
  logic signed [IW-1:0] top_lhs;
  logic signed [IW-1:0] top_max;

  if (Levels == 1) begin : g_top_lhs_in
    assign top_lhs = pool.ifm_input[0];
  end else begin : g_top_lhs_q
    assign top_lhs = node_q[OffLast];
  end

  if (NLast == 2) begin : g_top_pair
    logic signed [IW-1:0] top_rhs;
    if (Levels == 1) begin : g_top_rhs_in
      assign top_rhs = pool.ifm_input[1];
    end else begin : g_top_rhs_q
      assign top_rhs = node_q[OffLast + 1];
    end
    assign top_max = (top_rhs > top_lhs) ? top_rhs : top_lhs;
  end else begin : g_top_pass
    assign top_max = top_lhs;
  end

  // Width conversion happens only here; the tree itself stays INPUT_WIDTH wide.
  logic signed [OW-1:0] result;

  if (OW >= IW) begin : g_extend
    assign result = OW'(top_max);
  end else begin : g_saturate
    // Arithmetic shift of the IW-bit extremes yields the OW-bit signed range.
    localparam logic signed [IW-1:0] SatHi = $signed({1'b0, {(IW-1){1'b1}}}) >>> (IW - OW);
    localparam logic signed [IW-1:0] SatLo = $signed({1'b1, {(IW-1){1'b0}}}) >>> (IW - OW);
    logic signed [IW-1:0] clamped;
    assign clamped = (top_max > SatHi) ? SatHi :
                     (top_max < SatLo) ? SatLo : top_max;
    assign result  = clamped[OW-1:0];
  end

  logic signed [OW-1:0] out_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= result;
    end
  end

  assign pool.ifm_output = out_q;

endmodule

// File: tb/tb_max_pooling.sv
// Scoreboard bench for max_pooling: three instances share one stimulus stream
//   a : POOL_SIZE=4, OUTPUT_WIDTH=20 (default)
//   b : POOL_SIZE=4, OUTPUT_WIDTH=8  (saturating)
//   c : POOL_SIZE=3, OUTPUT_WIDTH=20 (odd window, uses samples 0..2)
// All three have a latency of 2, so one expected-result queue serves them.
module tb_max_pooling;

  logic clk;
  logic rst_n;

  max_pooling_if #(.INPUT_WIDTH(20), .OUTPUT_WIDTH(20), .POOL_SIZE(4)) if_a ();
  max_pooling_if #(.INPUT_WIDTH(20), .OUTPUT_WIDTH(8),  .POOL_SIZE(4)) if_b ();
  max_pooling_if #(.INPUT_WIDTH(20), .OUTPUT_WIDTH(20), .POOL_SIZE(3)) if_c ();

  max_pooling #(.INPUT_WIDTH(20), .OUTPUT_WIDTH(20), .POOL_SIZE(4)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .pool  (if_a)
  );

  max_pooling #(.INPUT_WIDTH(20), .OUTPUT_WIDTH(8), .POOL_SIZE(4)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .pool  (if_b)
  );

  max_pooling #(.INPUT_WIDTH(20), .OUTPUT_WIDTH(20), .POOL_SIZE(3)) u_dut_c (
    .clk   (clk),
    .rst_n (rst_n),
    .pool  (if_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int c;
  } exp_t;

  exp_t q_exp[$];
  int   n_total = 0;
  int   n_bad   = 0;

  task automatic check(input string tag, input int got, input int want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic int max_of(input int w0, input int w1, input int w2, input int w3);
    int m;
    m = w0;
    if (w1 > m) m = w1;
    if (w2 > m) m = w2;
    if (w3 > m) m = w3;
    return m;
  endfunction

  function automatic int sat8(input int v);
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // Present one window (and reset level) for one clock edge, then score the output.
  task automatic step(input bit r, input int w0, input int w1, input int w2, input int w3);
    exp_t e;
    exp_t nx;
    rst_n = r;
    if_a.ifm_input[0] = 20'(w0); if_a.ifm_input[1] = 20'(w1);
    if_a.ifm_input[2] = 20'(w2); if_a.ifm_input[3] = 20'(w3);
    if_b.ifm_input[0] = 20'(w0); if_b.ifm_input[1] = 20'(w1);
    if_b.ifm_input[2] = 20'(w2); if_b.ifm_input[3] = 20'(w3);
    if_c.ifm_input[0] = 20'(w0); if_c.ifm_input[1] = 20'(w1);
    if_c.ifm_input[2] = 20'(w2);
    @(posedge clk);
    #1;
    if (r) begin
      // Reset wipes everything in flight; the output and the next stage hold zero.
      q_exp.delete();
      check("rst_a", int'(if_a.ifm_output), 0);
      check("rst_b", int'(if_b.ifm_output), 0);
      check("rst_c", int'(if_c.ifm_output), 0);
      nx = '{a: 0, b: 0, c: 0};
    end else begin
      check("sb_depth", q_exp.size(), 1);
      if (q_exp.size() > 0) begin
        e = q_exp.pop_front();
        check("out_a", int'(if_a.ifm_output), e.a);
        check("out_b", int'(if_b.ifm_output), e.b);
        check("out_c", int'(if_c.ifm_output), e.c);
      end
      nx.a = max_of(w0, w1, w2, w3);
      nx.b = sat8(nx.a);
      nx.c = max_of(w0, w1, w2, w2);
    end
    q_exp.push_back(nx);
  endtask

  initial begin
    int v[4];
    rst_n = 1'b1;

    // Reset held for three edges with live inputs, then released with the same window.
    for (int i = 0; i < 3; i++) step(1'b1, 5, -3, 100, 7);
    step(1'b0, 5, -3, 100, 7);
    step(1'b0, 5, -3, 100, 7);

    // Signed ordering, ties and the 20-bit extremes.
    step(1'b0, -8, -1, -20, -524288);
    step(1'b0, 0, -1, -2, -3);
    step(1'b0, 524287, 524287, 3, 524287);
    step(1'b0, -524288, -524288, -524288, -524288);

    // Back-to-back windows.
    step(1'b0, 1, 2, 3, 4);
    step(1'b0, 40, 30, 20, 10);
    step(1'b0, -5, -6, -7, -9);

    // Saturation cases for the 8-bit output and an odd-window case.
    step(1'b0, 1000, 3, 2, 1);
    step(1'b0, -300, -400, -301, -999);
    step(1'b0, -5, -9, -6, -100);
    step(1'b0, 2, 9, -4, 50);

    // Single-edge reset in the middle of a stream.
    step(1'b0, 11, 12, 13, 14);
    step(1'b0, 21, 22, 23, 24);
    step(1'b1, 31, 32, 33, 34);
    step(1'b0, 41, 42, 43, 44);
    step(1'b0, 51, 52, 53, 54);

    // Random windows: full 20-bit range, mixed with a narrow band around the 8-bit limits.
    for (int it = 0; it < 50; it++) begin
      for (int j = 0; j < 4; j++) begin
        if (it % 3 == 0) v[j] = int'($urandom_range(0, 2000)) - 1000;
        else             v[j] = (int'($urandom) <<< 12) >>> 12;
      end
      step(1'b0, v[0], v[1], v[2], v[3]);
    end

    // Drain the last window.
    step(1'b0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
